data_mem_responder: RTL and testbench

// - Memory-side responder for the cpu data port: serves ram_addr2 loads, accepts mem_w_en stores.
// - Backing store is a single-port data array: one read OR one write per cycle.
// - Stores are posted into a write buffer (FIFO) and drain to the array only on cycles with no load.
// - Loads forward from the buffer (youngest match), so the cpu always sees fixed 1-cycle load latency.

---
 rtl/data_mem_responder_if.sv | 52 +++++
 rtl/data_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Purpose: cpu data-port bundle between the cpu (master) and the memory-side
//          responder (slave).
// Signals:
//   mem_r_en   master->slave  load request at ram_addr2
//   mem_w_en   master->slave  store request: ram_in2 -> ram_addr2
//   ram_addr2  master->slave  word address
//   ram_in2    master->slave  store data
//   ram_data2  slave->master  load data, valid the cycle after mem_r_en
//   rd_valid   slave->master  ram_data2 carries a fresh load result
//   wb_full    slave->master  write buffer full; cpu must not store
//   wb_empty   slave->master  write buffer empty; array up to date
//   wb_ovf     slave->master  sticky: a store was dropped on overflow
interface data_mem_responder_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
);

  logic              mem_r_en;
  logic              mem_w_en;
  logic [ADDR_W-1:0] ram_addr2;
  logic [DATA_W-1:0] ram_in2;
  logic [DATA_W-1:0] ram_data2;
  logic              rd_valid;
  logic              wb_full;
  logic              wb_empty;
  logic              wb_ovf;

  modport master (
    output mem_r_en,
    output mem_w_en,
    output ram_addr2,
    output ram_in2,
    input  ram_data2,
    input  rd_valid,
    input  wb_full,
    input  wb_empty,
    input  wb_ovf
  );

  modport slave (
    input  mem_r_en,
    input  mem_w_en,
    input  ram_addr2,
    input  ram_in2,
    output ram_data2,
    output rd_valid,
    output wb_full,
    output wb_empty,
    output wb_ovf
  );

endinterface

// File: rtl/data_mem_responder.sv
// Purpose: memory-side responder for the cpu data port. Loads read a
//          single-port data array with fixed 1-cycle latency; stores are
//          posted into a small write buffer that drains into the array on
//          cycles without a load. Loads forward from the youngest matching
//          buffered store so the cpu never sees stale data.
// Ports:
//   clk    clock, all state updates on posedge
//   rst_n  asynchronous active-low reset
//   bus    data_mem_responder_if.slave (request/response bundle)
module data_mem_responder #(
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WB_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  data_mem_responder_if.slave   bus
);

  localparam int unsigned PTR_W     = $clog2(WB_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned MEM_WORDS = 2 ** ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Write buffer storage and control
  wb_entry_t          wb_q [WB_DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic               full_c;
  logic               empty_c;
  logic               pop_c;
  logic               push_c;
  logic               drop_c;

  // Forwarding search results
  logic               fwd_hit_c;
  logic [DATA_W-1:0]  fwd_data_c;
  logic [PTR_W-1:0]   fwd_idx_c;

  // Data array and load pipeline
  logic [DATA_W-1:0]  mem_q [MEM_WORDS];
  logic [DATA_W-1:0]  arr_rdata_q;
  logic               rd_valid_q, rd_valid_d;
  logic               fwd_hit_q, fwd_hit_d;
  logic [DATA_W-1:0]  fwd_data_q, fwd_data_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic [DATA_W-1:0]  load_data_c;

  // Occupancy decode from the registered count
  assign full_c  = (count_q == CNT_W'(WB_DEPTH));
  assign empty_c = (count_q == '0);

  // Array port arbitration: a load owns the port, otherwise drain one entry.
  // A store while full can only be accepted if a drain frees a slot.
  assign pop_c  = !bus.mem_r_en && !empty_c;
  assign push_c = bus.mem_w_en && (!full_c || pop_c);
  assign drop_c = bus.mem_w_en && full_c && !pop_c;

  // Forward search over live entries, oldest to youngest; the last hit wins,
  // which is the same as scanning tail-1 back to head and taking the first.
  // Runs on pre-push state, so a same-cycle store is never forwarded.
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    fwd_idx_c  = '0;
    for (int unsigned i = 0; i < WB_DEPTH; i++) begin
      fwd_idx_c = PTR_W'(head_q + PTR_W'(i));
      if ((CNT_W'(i) < count_q) && (wb_q[fwd_idx_c].addr == bus.ram_addr2)) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = wb_q[fwd_idx_c].data;
      end
    end
  end

  // Buffer pointer / count / overflow next state
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q | drop_c;
    if (pop_c) begin
      head_d = PTR_W'(head_q + PTR_W'(1));
    end
    if (push_c) begin
      tail_d = PTR_W'(tail_q + PTR_W'(1));
    end
    case ({push_c, pop_c})
      2'b10:   count_d = CNT_W'(count_q + CNT_W'(1));
      2'b01:   count_d = CNT_W'(count_q - CNT_W'(1));
      default: count_d = count_q;
    endcase
  end

  // Load pipeline next state; hold_q keeps the last result between loads
  always_comb begin
    rd_valid_d = bus.mem_r_en;
    fwd_hit_d  = fwd_hit_q;
    fwd_data_d = fwd_data_q;
    hold_d     = hold_q;
    if (bus.mem_r_en) begin
      fwd_hit_d  = fwd_hit_c;
      fwd_data_d = fwd_data_c;
    end
    if (rd_valid_q) begin
      hold_d = load_data_c;
    end
  end

  // Control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      hold_q     <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
      hold_q     <= hold_d;
    end
  end

  // Buffer payload; contents are meaningless outside [head, head+count)
  always_ff @(posedge clk) begin
    if (push_c) begin
      wb_q[tail_q] <= '{addr: bus.ram_addr2, data: bus.ram_in2};
    end
  end

  // Single-port synchronous data array: one write (drain) or one read
  always_ff @(posedge clk) begin
    if (pop_c) begin
      mem_q[wb_q[head_q].addr] <= wb_q[head_q].data;
    end else if (bus.mem_r_en) begin
      arr_rdata_q <= mem_q[bus.ram_addr2];
    end
  end

  // Select forwarded or array data for the load issued last cycle
  assign load_data_c = fwd_hit_q ? fwd_data_q : arr_rdata_q;

  assign bus.ram_data2 = rd_valid_q ? load_data_c : hold_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.wb_full   = full_c;
  assign bus.wb_empty  = empty_c;
  assign bus.wb_ovf    = ovf_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the buffered memory.
module tb_data_mem_responder;

  localparam int unsigned ADDR_W   = 11;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned WB_DEPTH = 4;
  localparam int unsigned WORDS    = 2 ** ADDR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  data_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  data_mem_responder #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .WB_DEPTH(WB_DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: array image, FIFO of pending stores, expected outputs
  logic [DATA_W-1:0] mem_m [WORDS];
  logic [ADDR_W-1:0] qa [$];
  logic [DATA_W-1:0] qd [$];
  logic [DATA_W-1:0] exp_data  = '0;
  logic              exp_valid = 1'b0;
  logic              exp_ovf   = 1'b0;
  logic [DATA_W-1:0] m_d;
  bit                m_pop;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] init_val(logic [ADDR_W-1:0] a);
    return 32'hC0DE_0000 ^ (32'(a) * 32'h0000_9E37) ^ 32'h0000_0001;
  endfunction

  always @(negedge rst_n) begin
    qa.delete();
    qd.delete();
    exp_data  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
  end

  // Model step: load sees pre-push state (youngest match wins), then drain, then push
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.mem_r_en) begin
        m_d = mem_m[bus.ram_addr2];
        for (int i = qa.size() - 1; i >= 0; i--) begin
          if (qa[i] == bus.ram_addr2) begin
            m_d = qd[i];
            break;
          end
        end
        exp_data  = m_d;
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
      m_pop = !bus.mem_r_en && (qa.size() != 0);
      if (m_pop) begin
        mem_m[qa[0]] = qd[0];
        void'(qa.pop_front());
        void'(qd.pop_front());
      end
      if (bus.mem_w_en) begin
        if (qa.size() < int'(WB_DEPTH)) begin
          qa.push_back(bus.ram_addr2);
          qd.push_back(bus.ram_in2);
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    check("ram_data2", bus.ram_data2, exp_data);
    check("rd_valid", 32'(bus.rd_valid), 32'(exp_valid));
    check("wb_full", 32'(bus.wb_full), 32'(qa.size() == int'(WB_DEPTH)));
    check("wb_empty", 32'(bus.wb_empty), 32'(qa.size() == 0));
    check("wb_ovf", 32'(bus.wb_ovf), 32'(exp_ovf));
  end

  task automatic cyc(bit r, bit w, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    @(negedge clk);
    bus.mem_r_en  = r;
    bus.mem_w_en  = w;
    bus.ram_addr2 = a;
    bus.ram_in2   = d;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    bus.mem_r_en  = 1'b0;
    bus.mem_w_en  = 1'b0;
    bus.ram_addr2 = '0;
    bus.ram_in2   = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Preload the whole array through the buffer so model and DUT agree
    for (int a = 0; a < int'(WORDS); a++) begin
      mem_m[a] = 'x;
      cyc(1'b0, 1'b1, ADDR_W'(a), init_val(ADDR_W'(a)));
    end
    idle(6);
    check("preload_empty", 32'(bus.wb_empty), 32'd1);

    // Store then load next cycle: forwarded from buffer
    cyc(1'b0, 1'b1, 11'h010, 32'hDEADBEEF);
    cyc(1'b1, 1'b0, 11'h010, '0);
    cyc(1'b0, 1'b0, '0, '0);
    check("fwd_data", bus.ram_data2, 32'hDEADBEEF);
    check("fwd_valid", 32'(bus.rd_valid), 32'd1);
    idle(4);

    // Two stores same address: youngest forwarded, then drains to 0x2
    cyc(1'b0, 1'b1, 11'h020, 32'h1);
    cyc(1'b0, 1'b1, 11'h020, 32'h2);
    cyc(1'b1, 1'b0, 11'h020, '0);
    cyc(1'b0, 1'b0, '0, '0);
    check("youngest", bus.ram_data2, 32'h2);
    cyc(1'b0, 1'b0, '0, '0);
    check("drained_empty", 32'(bus.wb_empty), 32'd1);
    cyc(1'b1, 1'b0, 11'h020, '0);
    cyc(1'b0, 1'b0, '0, '0);
    check("array_020", bus.ram_data2, 32'h2);
    idle(2);

    // Full buffer with a drain cycle: push+pop, no overflow
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, ADDR_W'(11'h180 + i), 32'h100 + 32'(i));
    cyc(1'b0, 1'b1, 11'h7FF, 32'h55);
    cyc(1'b0, 1'b0, '0, '0);
    check("pp_full", 32'(bus.wb_full), 32'd1);
    check("pp_no_ovf", 32'(bus.wb_ovf), 32'd0);
    idle(5);
    cyc(1'b1, 1'b0, 11'h7FF, '0);
    cyc(1'b0, 1'b0, '0, '0);
    check("load_7ff", bus.ram_data2, 32'h55);

    // Same-cycle load+store: load sees old value
    cyc(1'b0, 1'b1, 11'h030, 32'hA);
    idle(2);
    cyc(1'b1, 1'b1, 11'h030, 32'hB);
    cyc(1'b1, 1'b0, 11'h030, '0);
    check("rw_old", bus.ram_data2, 32'hA);
    cyc(1'b0, 1'b0, '0, '0);
    check("rw_new", bus.ram_data2, 32'hB);
    idle(3);

    // Hold loads on a miss address and overfill
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, ADDR_W'(11'h100 + i), 32'h900 + 32'(i));
    cyc(1'b1, 1'b1, 11'h104, 32'h904);
    cyc(1'b1, 1'b0, 11'h300, '0);
    check("ovf_set", 32'(bus.wb_ovf), 32'd1);
    check("ovf_full", 32'(bus.wb_full), 32'd1);
    idle(4);
    cyc(1'b0, 1'b0, '0, '0);
    check("ovf_drained", 32'(bus.wb_empty), 32'd1);
    cyc(1'b1, 1'b0, 11'h104, '0);
    cyc(1'b0, 1'b0, '0, '0);
    check("dropped_104", bus.ram_data2, init_val(11'h104));

    // Async reset with three buffered stores
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, ADDR_W'(11'h200 + i), 32'h700 + 32'(i));
    cyc(1'b1, 1'b0, 11'h300, '0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_data", bus.ram_data2, 32'h0);
    check("rst_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_empty", 32'(bus.wb_empty), 32'd1);
    check("rst_ovf", 32'(bus.wb_ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    cyc(1'b1, 1'b0, 11'h200, '0);
    cyc(1'b0, 1'b0, '0, '0);
    check("rst_old_200", bus.ram_data2, init_val(11'h200));

    // Random traffic, biased toward a few hot addresses for forwarding hits
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 1)),
          ($urandom_range(0, 9) < 4),
          ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7)),
          32'($urandom));
    end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
